// File: rtl/string_hw_pkg.sv
// Shared types and constants for the string-core job arbiter: FSM states,
// block/length limits and small width helpers.
package string_hw_pkg;

    localparam int BYTES_PER_BLOCK    = 4;
    localparam int MAX_BLOCKS_DEFAULT = 8;
    localparam int MAX_LEN_DEFAULT    = BYTES_PER_BLOCK * MAX_BLOCKS_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LAUNCH  = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_e;

    function automatic int max_length(input int blocks);
        return BYTES_PER_BLOCK * blocks;
    endfunction

    // Width of a binary requester id; never zero so a single requester still has a port.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/string_job_arbiter_if.sv
// Requester-side and core-side signals of the string job arbiter, bundled
// with a slave view for the arbiter and a master view for whoever drives it.
interface string_job_arbiter_if #(
    parameter int NUM_REQ = 2
) ();
    import string_hw_pkg::*;

    localparam int ID_W = id_width(NUM_REQ);

    logic [NUM_REQ-1:0]      req;
    logic [NUM_REQ-1:0][3:0] req_index;
    logic [NUM_REQ-1:0][7:0] req_length;
    logic [NUM_REQ-1:0]      grant;
    logic [ID_W-1:0]         grant_id;
    logic [NUM_REQ-1:0]      job_done;
    logic [NUM_REQ-1:0]      job_err;
    logic                    core_go;
    logic [3:0]              core_index;
    logic [7:0]              core_length;
    logic                    core_done;
    logic                    busy;

    modport slave (
        input  req, req_index, req_length, core_done,
        output grant, grant_id, job_done, job_err,
        output core_go, core_index, core_length, busy
    );

    modport master (
        output req, req_index, req_length, core_done,
        input  grant, grant_id, job_done, job_err,
        input  core_go, core_index, core_length, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans requests starting at rr_ptr_i and
// returns the first hit as a one-hot winner (all-zero when nothing requests).
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   rr_ptr_i,
    output logic [NUM_REQ-1:0] winner_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // NOTE: every output and temporary gets a default before the loop so no path leaves a latch.
    always_comb begin
        winner_o = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = PTR_W'((int'(rr_ptr_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                winner_o[idx] = 1'b1;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/string_job_arbiter.sv
// Shares one string core between NUM_REQ requesters: round-robin grant,
// length validation, one-cycle launch strobe, completion/timeout reporting.
module string_job_arbiter
    import string_hw_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int MAX_BLOCKS     = MAX_BLOCKS_DEFAULT,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    string_job_arbiter_if.slave  bus
);

    localparam int ID_W    = id_width(NUM_REQ);
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int MAX_LEN = max_length(MAX_BLOCKS);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [ID_W-1:0]    grant_id_q, grant_id_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] job_done_q, job_done_d;
    logic [NUM_REQ-1:0] job_err_q, job_err_d;
    logic [3:0]         core_index_q, core_index_d;
    logic [7:0]         core_length_q, core_length_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               core_done_q;

    logic [NUM_REQ-1:0] winner;
    logic [ID_W-1:0]    win_id;
    logic [7:0]         win_length;
    logic               win_len_ok;
    logic               owner_req;
    logic               done_rise;
    logic [CNT_W-1:0]   wait_cnt_inc;
    logic               timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (ID_W)
    ) u_rr_arbiter (
        .req_i    (bus.req),
        .rr_ptr_i (rr_ptr_q),
        .winner_o (winner)
    );

    always_comb begin
        win_id = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) win_id = ID_W'(i);
        end
    end

    assign win_length   = bus.req_length[win_id];
    assign win_len_ok   = (win_length != 8'd0) && (int'(win_length) <= MAX_LEN);
    assign owner_req    = |(bus.req & grant_q);
    // Completion is an edge, so a core_done left high from an earlier job is ignored.
    assign done_rise    = bus.core_done & ~core_done_q;
    assign wait_cnt_inc = wait_cnt_q + 1'b1;
    assign timeout      = int'(wait_cnt_inc) >= (TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        core_index_d  = core_index_q;
        core_length_d = core_length_q;
        wait_cnt_d    = wait_cnt_q;
        job_done_d    = '0;
        job_err_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (|bus.req) begin
                    grant_d       = winner;
                    grant_id_d    = win_id;
                    core_index_d  = bus.req_index[win_id];
                    core_length_d = win_length;
                    rr_ptr_d      = (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + 1'b1;
                    if (win_len_ok) begin
                        state_d = ST_LAUNCH;
                    end else begin
                        job_err_d = winner;
                        state_d   = ST_RELEASE;
                    end
                end
            end
            ST_LAUNCH: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_inc;
                if (done_rise) begin
                    job_done_d = grant_q;
                    state_d    = ST_RELEASE;
                end else if (timeout) begin
                    job_err_d = grant_q;
                    state_d   = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!owner_req) begin
                    grant_d    = '0;
                    grant_id_d = '0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
            job_done_q    <= '0;
            job_err_q     <= '0;
            core_index_q  <= '0;
            core_length_q <= '0;
            wait_cnt_q    <= '0;
            core_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
            job_done_q    <= job_done_d;
            job_err_q     <= job_err_d;
            core_index_q  <= core_index_d;
            core_length_q <= core_length_d;
            wait_cnt_q    <= wait_cnt_d;
            core_done_q   <= bus.core_done;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_id    = grant_id_q;
    assign bus.job_done    = job_done_q;
    assign bus.job_err     = job_err_q;
    assign bus.core_go     = (state_q == ST_LAUNCH);
    assign bus.core_index  = core_index_q;
    assign bus.core_length = core_length_q;
    assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_string_job_arbiter.sv
// Self-checking bench for string_job_arbiter: single-job vector table, a
// completion scoreboard, and sequences for alternation, stale done and reset.
module tb_string_job_arbiter;

    typedef struct {
        bit         rid;
        logic [3:0] idx;
        logic [7:0] len;
        int         done_delay;   // cycles after the core_go cycle to raise core_done; -1 = never
        bit         drop_early;   // drop req one cycle after core_go
        bit         exp_go;
        bit         exp_err;
        int         exp_end;      // cycles from core_go to the done/err pulse
    } vec_t;

    typedef struct {
        logic [1:0] grant;
        logic       gid;
        logic       err;
        logic [3:0] idx;
        logic [7:0] len;
    } sb_item_t;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;

    sb_item_t   sb_q[$];
    sb_item_t   tb_e;
    sb_item_t   mon_e;
    vec_t       vecs[8];
    logic [1:0] alt_exp[3];
    int         lat;

    string_job_arbiter_if #(.NUM_REQ(2)) bus ();

    string_job_arbiter #(
        .NUM_REQ        (2),
        .MAX_BLOCKS     (8),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"},       32'(bus.grant),       0);
        check({tag, "_grant_id"},    32'(bus.grant_id),    0);
        check({tag, "_job_done"},    32'(bus.job_done),    0);
        check({tag, "_job_err"},     32'(bus.job_err),     0);
        check({tag, "_core_go"},     32'(bus.core_go),     0);
        check({tag, "_core_index"},  32'(bus.core_index),  0);
        check({tag, "_core_length"}, 32'(bus.core_length), 0);
        check({tag, "_busy"},        32'(bus.busy),        0);
    endtask

    // Steps negedges until core_go or a result pulse shows up, at most 8 cycles.
    task automatic wait_start(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.core_go && !(|bus.job_err) && !(|bus.job_done) && n < 8);
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] bit_w;
        int         t;
        int         gos;
        bit_w = 2'(2'b01 << v.rid);
        bus.req_index[v.rid]  = v.idx;
        bus.req_length[v.rid] = v.len;
        bus.req[v.rid]        = 1'b1;
        tb_e.grant = bit_w;
        tb_e.gid   = v.rid;
        tb_e.err   = v.exp_err;
        tb_e.idx   = v.idx;
        tb_e.len   = v.len;
        sb_q.push_back(tb_e);
        gos = 0;
        wait_start(lat);
        check("start_latency", lat, 1);
        check("start_grant", 32'(bus.grant), 32'(bit_w));
        check("start_busy", 32'(bus.busy), 1);
        if (bus.core_go) gos++;
        if (v.exp_go) begin
            t = 0;
            while (!(|bus.job_done) && !(|bus.job_err) && t < 40) begin
                if (v.done_delay >= 0 && t == v.done_delay) bus.core_done = 1'b1;
                if (v.drop_early && t == 1) bus.req[v.rid] = 1'b0;
                @(negedge clk);
                t++;
                if (bus.core_go) gos++;
            end
            check("end_latency", t, v.exp_end);
        end
        check("go_count", gos, 32'(v.exp_go));
        check("done_bits", 32'(bus.job_done), v.exp_err ? 0 : 32'(bit_w));
        check("err_bits", 32'(bus.job_err), v.exp_err ? 32'(bit_w) : 0);
        bus.core_done = 1'b0;
        @(negedge clk);
        check("pulse_width", 32'(bus.job_done | bus.job_err), 0);
        if (v.drop_early) begin
            check("release_early", 32'(bus.grant), 0);
        end else begin
            check("release_hold", 32'(bus.grant), 32'(bit_w));
            bus.req[v.rid] = 1'b0;
            @(negedge clk);
            check("release_grant", 32'(bus.grant), 0);
            check("release_busy", 32'(bus.busy), 0);
        end
    endtask

    // Scoreboard consumer plus per-cycle invariants on grant and result pulses.
    always @(negedge clk) begin
        if (reset_n) begin
            check("grant_onehot0", 32'($onehot0(bus.grant)), 1);
            check("done_err_exclusive", 32'(|(bus.job_done & bus.job_err)), 0);
            check("pulse_on_grant", 32'((bus.job_done | bus.job_err) & ~bus.grant), 0);
            if (|bus.job_done || |bus.job_err) begin
                check("sb_pending", 32'(sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    check("sb_grant", 32'(bus.grant), 32'(mon_e.grant));
                    check("sb_grant_id", 32'(bus.grant_id), 32'(mon_e.gid));
                    check("sb_outcome_err", 32'(|bus.job_err), 32'(mon_e.err));
                    check("sb_core_index", 32'(bus.core_index), 32'(mon_e.idx));
                    check("sb_core_length", 32'(bus.core_length), 32'(mon_e.len));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before the test ended");
        $fatal(1, "watchdog expired");
    end

    initial begin
        errors = 0;
        checks = 0;
        // rid, idx, len, done_delay, drop_early, exp_go, exp_err, exp_end
        vecs[0] = '{1'b0, 4'd3,  8'd12,  5, 1'b0, 1'b1, 1'b0, 6};
        vecs[1] = '{1'b1, 4'd9,  8'd32,  1, 1'b0, 1'b1, 1'b0, 2};
        vecs[2] = '{1'b1, 4'd1,  8'd0,   0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{1'b1, 4'd2,  8'd33,  0, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{1'b0, 4'd15, 8'd1,   3, 1'b1, 1'b1, 1'b0, 4};
        vecs[5] = '{1'b0, 4'd6,  8'd20, -1, 1'b0, 1'b1, 1'b1, 16};
        vecs[6] = '{1'b1, 4'd7,  8'd255, 0, 1'b0, 1'b0, 1'b1, 0};
        vecs[7] = '{1'b1, 4'd12, 8'd31,  2, 1'b1, 1'b1, 1'b0, 3};
        alt_exp[0] = 2'b01;
        alt_exp[1] = 2'b10;
        alt_exp[2] = 2'b01;

        reset_n        = 1'b0;
        bus.req        = '0;
        bus.req_index  = '0;
        bus.req_length = '0;
        bus.core_done  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
            @(negedge clk);
        end

        // Both requesters held from reset: strict alternation starting at 0.
        bus.req_index  = {4'd5, 4'd4};
        bus.req_length = {8'd8, 8'd8};
        bus.req        = 2'b11;
        reset_n        = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int r = 0; r < 3; r++) begin
            tb_e.grant = alt_exp[r];
            tb_e.gid   = alt_exp[r][1];
            tb_e.err   = 1'b0;
            tb_e.idx   = alt_exp[r][1] ? 4'd5 : 4'd4;
            tb_e.len   = 8'd8;
            sb_q.push_back(tb_e);
            wait_start(lat);
            check("alt_latency", lat, 1);
            check("alt_grant", 32'(bus.grant), 32'(alt_exp[r]));
            @(negedge clk);
            bus.core_done = 1'b1;
            @(negedge clk);
            check("alt_done", 32'(bus.job_done), 32'(alt_exp[r]));
            bus.core_done = 1'b0;
            bus.req       = bus.req & ~alt_exp[r];
            @(negedge clk);
            check("alt_release", 32'(bus.grant), 0);
            bus.req = (r < 2) ? 2'b11 : 2'b00;
        end
        @(negedge clk);

        // core_done already high when the job starts: only a fresh rise completes it.
        bus.core_done     = 1'b1;
        @(negedge clk);
        bus.req_index[1]  = 4'd8;
        bus.req_length[1] = 8'd16;
        bus.req[1]        = 1'b1;
        tb_e = '{2'b10, 1'b1, 1'b0, 4'd8, 8'd16};
        sb_q.push_back(tb_e);
        wait_start(lat);
        check("stale_latency", lat, 1);
        check("stale_go", 32'(bus.core_go), 1);
        repeat (4) begin
            @(negedge clk);
            check("stale_done_ignored", 32'(bus.job_done), 0);
        end
        bus.core_done = 1'b0;
        @(negedge clk);
        check("stale_low_no_done", 32'(bus.job_done), 0);
        bus.core_done = 1'b1;
        @(negedge clk);
        check("stale_rise_done", 32'(bus.job_done), 32'(2'b10));
        bus.core_done = 1'b0;
        bus.req[1]    = 1'b0;
        @(negedge clk);
        check("stale_release", 32'(bus.grant), 0);
        @(negedge clk);

        // Reset mid-WAIT after serving requester 0 (pointer would favour 1).
        bus.req_index[0]  = 4'd11;
        bus.req_length[0] = 8'd8;
        bus.req[0]        = 1'b1;
        wait_start(lat);
        check("kill_go", 32'(bus.core_go), 1);
        repeat (3) @(negedge clk);
        check("kill_busy_before", 32'(bus.busy), 1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("async_reset");
        bus.req       = '0;
        bus.core_done = 1'b1;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("no_done_after_reset", 32'(bus.job_done | bus.job_err), 0);
        end
        bus.core_done  = 1'b0;
        bus.req_index  = {4'd10, 4'd14};
        bus.req_length = {8'd5, 8'd6};
        bus.req        = 2'b11;
        tb_e = '{2'b01, 1'b0, 1'b0, 4'd14, 8'd6};
        sb_q.push_back(tb_e);
        wait_start(lat);
        check("post_reset_latency", lat, 1);
        check("post_reset_grant", 32'(bus.grant), 32'(2'b01));
        @(negedge clk);
        bus.core_done = 1'b1;
        @(negedge clk);
        check("post_reset_done", 32'(bus.job_done), 32'(2'b01));
        bus.core_done = 1'b0;
        bus.req       = '0;
        repeat (2) @(negedge clk);
        check("final_idle", 32'(bus.busy), 0);
        check("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/string_job_arbiter.md
STRING_JOB_ARBITER -- requirements
Module: string_job_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2: number of requesters sharing one string core.
REQ-002 SHALL have parameter MAX_BLOCKS, default 8: 32-bit blocks per string; max legal length = 4*MAX_BLOCKS.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024: WAIT-state watchdog limit.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset_n  input  1  asynchronous active-low reset.
REQ-007 req  input  NUM_REQ  per-requester job request, level; held until result read.
REQ-008 req_index  input  NUM_REQ x 4  per-requester core index field.
REQ-009 req_length  input  NUM_REQ x 8  per-requester string length in characters.
REQ-010 grant  output  NUM_REQ  one-hot owner of core and A/B/Result muxes; all-zero when free.
REQ-011 grant_id  output  clog2(NUM_REQ)  binary encoding of grant, for mux selection.
REQ-012 job_done  output  NUM_REQ  one-cycle pulse to owner on normal completion.
REQ-013 job_err  output  NUM_REQ  one-cycle pulse to owner on rejected or timed-out job.
REQ-014 core_go  output  1  start strobe to string core.
REQ-015 core_index  output  4  registered index to core.
REQ-016 core_length  output  8  registered length to core.
REQ-017 core_done  input  1  core done level.
REQ-018 busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, LAUNCH, WAIT, RELEASE.
REQ-020 IDLE: on any req high at a clock edge, SHALL pick winner round-robin starting at rr_ptr, assert grant[w], latch req_index[w]/req_length[w] into core_index/core_length, set rr_ptr = (w+1) mod NUM_REQ, enter LAUNCH.
REQ-021 IDLE with latched length 0 or > 4*MAX_BLOCKS: SHALL skip LAUNCH, pulse job_err[w] the next cycle and enter RELEASE; core_go stays 0.
REQ-022 LAUNCH: core_go SHALL be high for exactly this one cycle; wait counter cleared; next state WAIT.
REQ-023 WAIT: completion = rising edge of core_done (core_done high, previous-cycle registered core_done low); SHALL pulse job_done[w] one cycle and enter RELEASE.
REQ-024 WAIT: counter increments each cycle; when it reaches TIMEOUT_CYCLES-1 without completion SHALL pulse job_err[w] and enter RELEASE; completion and timeout in same cycle resolves as completion.
REQ-025 RELEASE: grant[w] and core_index/core_length SHALL hold until req[w] is sampled low, then return to IDLE with grant all-zero the next cycle.
REQ-026 Deassertion of req[w] during LAUNCH/WAIT SHALL NOT abort the job; completion pulse still issued, then RELEASE exits immediately.
REQ-027 Requests from non-owners SHALL be ignored until IDLE; grant SHALL never change outside IDLE->LAUNCH/RELEASE->IDLE.
REQ-028 Latency: req edge to core_go = 2 cycles (IDLE sample, LAUNCH); core_done rise to job_done = 1 cycle.
REQ-029 grant SHALL be one-hot or zero at all times; job_done/job_err SHALL only assert on the granted bit and never together.

Reset
REQ-030 reset_n low SHALL force IDLE, grant=0, grant_id=0, job_done=0, job_err=0, core_go=0, core_index=0, core_length=0, busy=0, rr_ptr=0, wait counter=0, registered core_done=0, immediately and mid-job.
REQ-031 After reset release, first arbitration SHALL favour requester 0.

Structure
REQ-032 State enum, MAX_BLOCKS default and max-length constant SHALL live in shared package string_hw_pkg.
REQ-033 Round-robin winner selection SHALL be a sub-module rr_arbiter (inputs req, rr_ptr; output one-hot winner), purely combinational.

Verification
REQ-034 req=01, length 12, core_done rises 5 cycles after go -> go 2 cycles after req, grant=01, job_done[0] pulse 1 cycle after done rise, IDLE after req[0] drops.
REQ-035 req=11 held from reset -> grant 01 first, then 10, then 01 (strict alternation).
REQ-036 req[1] with length 0 and with length 33 (MAX_BLOCKS=8) -> job_err[1] pulse, core_go never asserted.
REQ-037 core_done held low, TIMEOUT_CYCLES=16 -> job_err pulse exactly 16 cycles after LAUNCH, then RELEASE.
REQ-038 reset_n pulsed low during WAIT -> all outputs zero same cycle asynchronously, no job_done afterward; next request served as requester 0 priority.
REQ-039 core_done already high entering WAIT -> no completion until it falls and rises again.
